window_gen: RTL
===============

# window_gen

Raster-to-window generator feeding `conv_block`. Accepts one pixel per cycle in raster order (row-major, left to right, top to bottom) and produces the full KERNEL_SIZE×KERNEL_SIZE neighbourhood needed for one convolution, with a valid strobe. It holds KERNEL_SIZE-1 line buffers and a KERNEL_SIZE×KERNEL_SIZE shift window. Only fully in-image windows are emitted (no border padding).

## Interface
- NBIT, 8, pixel width in bits
- KERNEL_SIZE, 3, window side; ≥ 2
- IMG_WIDTH, 640, pixels per line; ≥ KERNEL_SIZE
- IMG_HEIGHT, 480, lines per frame; ≥ KERNEL_SIZE

- i_clk  input  1  clock, all logic on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_pixel  input  NBIT  incoming pixel
- i_pixel_valid  input  1  i_pixel is accepted this cycle
- i_frame_start  input  1  qualified by i_pixel_valid; forces the accepted pixel to position (0,0)
- o_window  output  NBIT × [KERNEL_SIZE][KERNEL_SIZE]  window, unpacked as [row][col]
- o_window_valid  output  1  o_window holds a complete window this cycle
- o_frame_done  output  1  one-cycle pulse with the last window of a frame

## Operation
- Position counters: col (0..IMG_WIDTH-1), row (0..IMG_HEIGHT-1) give the position of the pixel being accepted. They advance only on i_pixel_valid. col wraps to 0 and increments row. After (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0, so the next frame starts with no reset.
- i_frame_start with i_pixel_valid: the pixel is treated as (0,0), and the counters continue from (0,1). Mid-frame assertion abandons the current frame. No o_frame_done is produced for the abandoned frame.
- Line buffers: KERNEL_SIZE-1 buffers of IMG_WIDTH×NBIT, addressed by col. On each accepted pixel, buffer k is read at col and written with the value read from buffer k-1 (buffer 0 is written with i_pixel). Read-before-write at the same address.
- Window register: on each accepted pixel, every window row shifts left by one column. Column KERNEL_SIZE-1 loads the new vertical slice: row KERNEL_SIZE-1 = i_pixel, row KERNEL_SIZE-2 = buffer 0 output, …, row 0 = buffer KERNEL_SIZE-2 output.
- Content rule: when the pixel at (r,c) is accepted, o_window[i][j] = pixel(r-KERNEL_SIZE+1+i, c-KERNEL_SIZE+1+j). Therefore o_window[KERNEL_SIZE-1][KERNEL_SIZE-1] is the newest pixel.
- Validity: o_window_valid = 1 iff the accepted pixel has r ≥ KERNEL_SIZE-1 and c ≥ KERNEL_SIZE-1.
  - Windows straddling a line wrap are never flagged valid.
  - Stale line-buffer data from the previous frame or before reset is masked by the row gate.
- Window count: each frame yields (IMG_HEIGHT-KERNEL_SIZE+1)×(IMG_WIDTH-KERNEL_SIZE+1) valid windows.
- o_frame_done = 1 together with the window of pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
- No backpressure: the downstream block must consume every valid window.

## Timing
- Latency: 1 cycle. A pixel accepted at edge N produces its o_window / o_window_valid / o_frame_done visible after edge N, i.e. during cycle N+1.
- o_window_valid and o_frame_done are single-cycle strobes. They deassert on the next edge, including when i_pixel_valid = 0.
- o_window holds its value while i_pixel_valid = 0. Gaps of any length do not disturb counters or contents.
- Throughput: one pixel per cycle, sustained indefinitely.
- Reset (i_rst = 1 at an edge):
  - col = row = 0
  - o_window all zeros
  - o_window_valid = 0, o_frame_done = 0
  - Line-buffer RAM is not cleared.
  - i_rst wins over simultaneous i_pixel_valid; that pixel is dropped.
- Reset mid-frame: the first accepted pixel afterwards is (0,0). No valid window appears until row KERNEL_SIZE-1, col KERNEL_SIZE-1 of the new frame.

## Test plan
- Basic window, K=3, W=5, H=4, pixel value = 5r+c, continuous valid → first o_window_valid one cycle after pixel 12. Window [0][0]=0, [0][2]=2, [1][1]=6, [2][0]=10, [2][2]=12.
- Same frame, count strobes → exactly 6 valid windows: after pixels 12, 13, 14, 17, 18, 19. None after pixels 15 or 16. o_frame_done only with pixel 19, whose window is [0][0]=7, [2][2]=19.
- Random i_pixel_valid gaps (50% duty) on the same frame → identical window sequence and values. Strobes never exceed one cycle. o_window is stable during gaps.
- Two back-to-back frames, second frame value = 5r+c+100 → second frame's first window is [0][0]=100, [2][2]=112, with no contamination from frame one.
- i_rst asserted after pixel 13 with valid held high, then the frame restarted → no strobe during or just after reset. Outputs are zero in the cycle after reset. The first window follows restarted pixel 12.
- i_frame_start asserted with the pixel at (2,3) → that pixel is taken as (0,0). No o_frame_done for the aborted frame. Valid windows resume 12 accepted pixels later.

Source files
------------

// File: rtl/window_gen.sv
// window_gen: raster-to-window generator producing KERNEL_SIZE x KERNEL_SIZE
// neighbourhoods with a valid strobe for conv_block.
//
// Ports:
//   i_clk          clock, all logic on rising edge
//   i_rst          synchronous active-high reset
//   i_pixel        incoming pixel, raster order
//   i_pixel_valid  i_pixel accepted this cycle
//   i_frame_start  with i_pixel_valid, forces the pixel to position (0,0)
//   o_window       [row][col] neighbourhood, [K-1][K-1] is the newest pixel
//   o_window_valid o_window is a complete in-image window (1-cycle strobe)
//   o_frame_done   pulses with the last window of a frame
module window_gen #(
    parameter int NBIT        = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [NBIT-1:0] i_pixel,
    input  logic            i_pixel_valid,
    input  logic            i_frame_start,
    output logic [NBIT-1:0] o_window [KERNEL_SIZE][KERNEL_SIZE],
    output logic            o_window_valid,
    output logic            o_frame_done
);

    localparam int K   = KERNEL_SIZE;
    localparam int NLB = KERNEL_SIZE - 1;
    localparam int CW  = $clog2(IMG_WIDTH);
    localparam int RW  = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_GATE = CW'(KERNEL_SIZE - 1);
    localparam logic [RW-1:0] ROW_GATE = RW'(KERNEL_SIZE - 1);

    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [CW-1:0]   cur_col;
    logic [RW-1:0]   cur_row;

    logic [NBIT-1:0] lb_mem [NLB][IMG_WIDTH];
    logic [NBIT-1:0] lb_rd  [NLB];
    logic [NBIT-1:0] slice  [K];

    // Position of the pixel being accepted; a frame start overrides the
    // running counters so the pixel lands at (0,0).
    always_comb begin
        cur_col = i_frame_start ? '0 : col;
        cur_row = i_frame_start ? '0 : row;
    end

    // Combinational read gives read-before-write at the same column.
    always_comb begin
        for (int k = 0; k < NLB; k++) begin
            lb_rd[k] = lb_mem[k][cur_col];
        end
    end

    // New vertical slice: bottom row is the live pixel, each row above
    // comes from one line further back.
    always_comb begin
        slice[K-1] = i_pixel;
        for (int i = 0; i < K - 1; i++) begin
            slice[i] = lb_rd[K-2-i];
        end
    end

    // Line buffers cascade: each one takes what the previous held for
    // this column. Contents survive reset; the row gate masks them.
    always_ff @(posedge i_clk) begin
        if (i_pixel_valid && !i_rst) begin
            lb_mem[0][cur_col] <= i_pixel;
            for (int k = 1; k < NLB; k++) begin
                lb_mem[k][cur_col] <= lb_rd[k-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col            <= '0;
            row            <= '0;
            o_window_valid <= 1'b0;
            o_frame_done   <= 1'b0;
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    o_window[i][j] <= '0;
                end
            end
        end else begin
            o_window_valid <= 1'b0;
            o_frame_done   <= 1'b0;
            if (i_pixel_valid) begin
                for (int i = 0; i < K; i++) begin
                    for (int j = 0; j < K - 1; j++) begin
                        o_window[i][j] <= o_window[i][j+1];
                    end
                    o_window[i][K-1] <= slice[i];
                end

                // Both gates together reject line-wrap windows and any
                // rows not yet filled in the current frame.
                o_window_valid <= (cur_row >= ROW_GATE) &&
                                  (cur_col >= COL_GATE);
                o_frame_done   <= (cur_row == ROW_LAST) &&
                                  (cur_col == COL_LAST);

                if (cur_col == COL_LAST) begin
                    col <= '0;
                    row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
                end else begin
                    col <= cur_col + 1'b1;
                    row <= cur_row;
                end
            end
        end
    end

endmodule
